// File: rtl/eth_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_pkg
//  Brief    : Shared types and constants for the Ethernet receive frame buffer.
//  Revision : 1.0  initial release
// ============================================================================
package eth_rx_pkg;

    // Legal Ethernet frame length window, FCS included.
    localparam int ETH_MIN_LEN = 64;
    localparam int ETH_MAX_LEN = 1518;

    // Frame length counter width; saturates at 4095.
    localparam int LEN_W = 12;

    // Why a frame was discarded.
    typedef enum logic [2:0] {
        DR_NONE = 3'd0,
        DR_OVF  = 3'd1,
        DR_ERR  = 3'd2,
        DR_RUNT = 3'd3,
        DR_LONG = 3'd4
    } drop_reason_t;

    // Write-side frame capture state.
    typedef enum logic [1:0] {
        FB_IDLE    = 2'd0,
        FB_RECV    = 2'd1,
        FB_DISCARD = 2'd2
    } rx_fb_state_t;

    // Length increment that sticks at the all-ones value.
    function automatic logic [LEN_W-1:0] len_inc_sat(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] one;
        one = {{(LEN_W-1){1'b0}}, 1'b1};
        return (&len) ? len : (len + one);
    endfunction

endpackage : eth_rx_pkg
`default_nettype wire

// File: rtl/rx_fb_ram.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fb_ram
//  Brief    : Simple dual-port RAM, one write port and one registered read
//             port. Read data holds its value while rd_en_i is low.
//  Revision : 1.0  initial release
// ============================================================================
module rx_fb_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : rx_fb_ram
`default_nettype wire

// File: rtl/rx_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : rx_frame_buffer
//  Brief    : Store-and-forward receive buffer. Captures each incoming frame,
//             commits it only when it ends clean with a legal length, else
//             rewinds the write pointer. Committed frames are streamed out on
//             a valid/ready byte interface.
//  Options  : RX_FB_STATS_EN - build the 32-bit per-outcome frame counters;
//             when undefined the stat_* outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module rx_frame_buffer
    import eth_rx_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic        in_error,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        frame_ok,
    output logic        frame_drop,
    output logic [2:0]  drop_why,
    output logic [31:0] stat_good,
    output logic [31:0] stat_err,
    output logic [31:0] stat_runt,
    output logic [31:0] stat_long,
    output logic [31:0] stat_ovf
);

    localparam logic [ADDR_W:0]  DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    rx_fb_state_t     state_q,      state_d;
    logic [ADDR_W:0]  wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W:0]  commit_ptr_q, commit_ptr_d;
    logic [LEN_W-1:0] len_q,        len_d;
    logic             err_q,        err_d;
    logic             ovf_q,        ovf_d;
    logic             hold_vld_q,   hold_vld_d;
    logic [7:0]       hold_data_q,  hold_data_d;
    // A byte arrived together with in_last; its hold entry is closed out
    // on the following cycle because the RAM has a single write port.
    logic             fin_q,        fin_d;
    logic             frame_ok_q,   frame_ok_d;
    logic             frame_drop_q, frame_drop_d;
    drop_reason_t     drop_why_q,   drop_why_d;

    // Read side state
    logic [ADDR_W:0]  rd_ptr_q;
    logic             rdv_q;
    logic             m_valid_q;
    logic [7:0]       m_data_q;
    logic             m_last_q;

    // RAM interface and helpers
    logic             ram_we;
    logic [8:0]       ram_wdata;
    logic [8:0]       ram_rdata;
    logic             rd_en;
    logic             out_load;
    logic             rd_avail;
    logic             wr_full;
    logic             end_evt;
    logic             end_ovf;
    logic             end_err;
    drop_reason_t     end_why;
    logic [LEN_W-1:0] len_nx;
    logic             do_start;

    assign wr_full = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign end_evt = fin_q || ((state_q != FB_IDLE) && in_last && !in_valid);

    rx_fb_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (9)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (ram_wdata),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (ram_rdata)
    );

    // Write FSM state and frame bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FB_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_data_q  <= '0;
            fin_q        <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_drop_q <= 1'b0;
            drop_why_q   <= DR_NONE;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            len_q        <= len_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            hold_vld_q   <= hold_vld_d;
            hold_data_q  <= hold_data_d;
            fin_q        <= fin_d;
            frame_ok_q   <= frame_ok_d;
            frame_drop_q <= frame_drop_d;
            drop_why_q   <= drop_why_d;
        end
    end

    // Write FSM next state: hold-register writes, frame checks, commit/rewind.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        err_d        = err_q;
        ovf_d        = ovf_q;
        hold_vld_d   = hold_vld_q;
        hold_data_d  = hold_data_q;
        fin_d        = 1'b0;
        frame_ok_d   = 1'b0;
        frame_drop_d = 1'b0;
        drop_why_d   = DR_NONE;
        ram_we       = 1'b0;
        ram_wdata    = {1'b0, hold_data_q};
        end_ovf      = ovf_q;
        end_err      = err_q;
        end_why      = DR_NONE;
        len_nx       = len_inc_sat(len_q);
        do_start     = 1'b0;

        if (end_evt) begin
            // Close the frame: the held byte becomes the last RAM entry.
            if ((state_q == FB_RECV) && hold_vld_q) begin
                if (wr_full) begin
                    end_ovf = 1'b1;
                end else begin
                    ram_we    = 1'b1;
                    ram_wdata = {1'b1, hold_data_q};
                end
            end
            // In the deferred cycle in_error already belongs to the next frame.
            end_err = err_q | (in_error & ~fin_q);

            if (end_ovf) begin
                end_why = DR_OVF;
            end else if (end_err) begin
                end_why = DR_ERR;
            end else if (len_q < MIN_L) begin
                end_why = DR_RUNT;
            end else if (len_q > MAX_L) begin
                end_why = DR_LONG;
            end

            if (end_why != DR_NONE) begin
                wr_ptr_d     = commit_ptr_q;
                frame_drop_d = 1'b1;
                drop_why_d   = end_why;
            end else begin
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                commit_ptr_d = wr_ptr_q + PTR_ONE;
                frame_ok_d   = 1'b1;
            end

            state_d    = FB_IDLE;
            hold_vld_d = 1'b0;
            len_d      = '0;
            err_d      = 1'b0;
            ovf_d      = 1'b0;
            // The next frame may begin in the same cycle as the deferred close.
            do_start   = fin_q && in_valid;
        end else begin
            case (state_q)
                FB_IDLE: begin
                    if (in_valid) begin
                        do_start = 1'b1;
                    end else if (in_last) begin
                        frame_drop_d = 1'b1;
                        drop_why_d   = DR_RUNT;
                    end
                end
                FB_RECV: begin
                    if (in_error) begin
                        err_d = 1'b1;
                    end
                    if (in_valid) begin
                        len_d = len_nx;
                        if (wr_full) begin
                            ovf_d   = 1'b1;
                            state_d = FB_DISCARD;
                        end else begin
                            ram_we    = 1'b1;
                            ram_wdata = {1'b0, hold_data_q};
                            wr_ptr_d  = wr_ptr_q + PTR_ONE;
                        end
                        hold_data_d = in_data;
                        if (len_nx > MAX_L) begin
                            state_d = FB_DISCARD;
                        end
                        fin_d = in_last;
                    end
                end
                FB_DISCARD: begin
                    if (in_error) begin
                        err_d = 1'b1;
                    end
                    if (in_valid) begin
                        len_d = len_nx;
                        fin_d = in_last;
                    end
                end
                default: begin
                    state_d = FB_IDLE;
                end
            endcase
        end

        if (do_start) begin
            state_d     = FB_RECV;
            len_d       = LEN_ONE;
            err_d       = in_error;
            ovf_d       = 1'b0;
            hold_vld_d  = 1'b1;
            hold_data_d = in_data;
            fin_d       = in_last;
        end
    end

    // ------------------------------------------------------------------
    // Read side: RAM output stage feeding a 1-deep output register
    // ------------------------------------------------------------------

    // Read issue: refill the RAM stage whenever it is empty or draining.
    always_comb begin
        rd_avail = (rd_ptr_q != commit_ptr_q);
        out_load = rdv_q && (!m_valid_q || m_ready);
        rd_en    = rd_avail && (!rdv_q || out_load);
    end

    // Read pointer, RAM-stage valid and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            rdv_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            rdv_q <= rd_en | (rdv_q & ~out_load);
            if (out_load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= ram_rdata[7:0];
                m_last_q  <= ram_rdata[8];
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign frame_ok   = frame_ok_q;
    assign frame_drop = frame_drop_q;
    assign drop_why   = drop_why_q;

    // ------------------------------------------------------------------
    // Optional frame statistics
    // ------------------------------------------------------------------
`ifdef RX_FB_STATS_EN
    logic [31:0] stat_good_q;
    logic [31:0] stat_err_q;
    logic [31:0] stat_runt_q;
    logic [31:0] stat_long_q;
    logic [31:0] stat_ovf_q;

    // Wrapping counters driven by the registered outcome pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good_q <= '0;
            stat_err_q  <= '0;
            stat_runt_q <= '0;
            stat_long_q <= '0;
            stat_ovf_q  <= '0;
        end else begin
            if (frame_ok_q) begin
                stat_good_q <= stat_good_q + 32'd1;
            end
            if (frame_drop_q) begin
                case (drop_why_q)
                    DR_OVF:  stat_ovf_q  <= stat_ovf_q  + 32'd1;
                    DR_ERR:  stat_err_q  <= stat_err_q  + 32'd1;
                    DR_RUNT: stat_runt_q <= stat_runt_q + 32'd1;
                    DR_LONG: stat_long_q <= stat_long_q + 32'd1;
                    default: ;
                endcase
            end
        end
    end

    assign stat_good = stat_good_q;
    assign stat_err  = stat_err_q;
    assign stat_runt = stat_runt_q;
    assign stat_long = stat_long_q;
    assign stat_ovf  = stat_ovf_q;
`else
    assign stat_good = '0;
    assign stat_err  = '0;
    assign stat_runt = '0;
    assign stat_long = '0;
    assign stat_ovf  = '0;
`endif

endmodule : rx_frame_buffer
`default_nettype wire
